// File: rtl/epsilon_pipe.sv
// Windowed sample stage: registered pass, saturated moving sum or moving
// average over the last 2**DEPTH_LOG2 accepted samples.
module epsilon_pipe #(
    parameter int WIDTH      = 20,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] D_out,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [1:0]              mode,
    input  logic                    clear,
    output logic signed [WIDTH-1:0] E_out,
    output logic                    e_valid,
    input  logic                    e_ready,
    output logic                    filled
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = WIDTH + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic signed [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] hist [DEPTH];
    logic [DEPTH_LOG2-1:0]   ptr;
    logic [DEPTH_LOG2:0]     count;
    logic signed [SW-1:0]    sum;

    logic                    accept;
    logic signed [WIDTH-1:0] oldest;
    logic signed [SW-1:0]    sum_base;
    logic signed [SW-1:0]    sum_next;
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2:0]     cnt_base;
    logic                    fits;
    logic signed [WIDTH-1:0] sat;
    logic signed [WIDTH-1:0] avg;
    logic signed [WIDTH-1:0] res;

    assign d_ready = !e_valid || e_ready;
    assign accept  = d_valid && d_ready;
    assign filled  = (count == FULL);

    // A clear on the accepting edge makes the window look empty first.
    always_comb begin
        oldest   = clear ? '0 : hist[ptr];
        sum_base = clear ? '0 : sum;
        wptr     = clear ? '0 : ptr;
        cnt_base = clear ? '0 : count;
        sum_next = sum_base
                 + {{DEPTH_LOG2{D_out[WIDTH-1]}}, D_out}
                 - {{DEPTH_LOG2{oldest[WIDTH-1]}}, oldest};
        fits = (&sum_next[SW-1:WIDTH-1]) || !(|sum_next[SW-1:WIDTH-1]);
        sat  = fits ? sum_next[WIDTH-1:0] : (sum_next[SW-1] ? VMIN : VMAX);
        avg  = WIDTH'(sum_next >>> DEPTH_LOG2);
        res  = D_out;
        unique case (1'b1)
            (mode == 2'd1): res = sat;
            (mode == 2'd2): res = avg;
            default:        res = D_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            ptr     <= '0;
            count   <= '0;
            sum     <= '0;
            E_out   <= '0;
            e_valid <= 1'b0;
        end else begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
                ptr   <= '0;
                count <= '0;
                sum   <= '0;
            end
            if (accept) begin
                hist[wptr] <= D_out;
                ptr        <= wptr + 1'b1;
                count      <= (cnt_base == FULL) ? cnt_base : cnt_base + 1'b1;
                sum        <= sum_next;
                E_out      <= res;
                e_valid    <= 1'b1;
            end else if (e_ready) begin
                e_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_epsilon_pipe.sv
// Directed bench for epsilon_pipe: pass, moving sum/average, stall, clear
// and reset behaviour against hand-computed values.
module tb_epsilon_pipe;

    logic               clk;
    logic               reset;
    logic signed [19:0] D_out;
    logic               d_valid;
    logic               d_ready;
    logic [1:0]         mode;
    logic               clear;
    logic signed [19:0] E_out;
    logic               e_valid;
    logic               e_ready;
    logic               filled;

    int nvec = 0;
    int nerr = 0;

    epsilon_pipe #(.WIDTH(20), .DEPTH_LOG2(3)) dut (
        .clk(clk),
        .reset(reset),
        .D_out(D_out),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .mode(mode),
        .clear(clear),
        .E_out(E_out),
        .e_valid(e_valid),
        .e_ready(e_ready),
        .filled(filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        d_valid = 1'b1;
        D_out   = 20'sd524287;
        e_ready = 1'b1;
        mode    = 2'd0;
        clear   = 1'b0;
        tick;
        chk("rst_eout", E_out, 0);
        chk("rst_evalid", e_valid, 0);
        chk("rst_filled", filled, 0);
        chk("rst_dready", d_ready, 1);

        reset = 1'b0;
        D_out = 20'sd12345;
        tick;
        chk("pass_eout", E_out, 12345);
        chk("pass_evalid", e_valid, 1);

        d_valid = 1'b0;
        clear   = 1'b1;
        tick;
        chk("clr_evalid", e_valid, 0);
        chk("clr_eout_kept", E_out, 12345);
        chk("clr_filled", filled, 0);
        clear = 1'b0;

        mode    = 2'd2;
        d_valid = 1'b1;
        D_out   = 20'sd800;
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk("avg_ramp", E_out, 100 * i);
            chk("avg_filled", filled, (i == 8) ? 1 : 0);
        end
        D_out = 20'sd0;
        tick;
        chk("avg_ninth", E_out, 700);
        chk("avg_ninth_filled", filled, 1);

        d_valid = 1'b0;
        clear   = 1'b1;
        tick;
        clear   = 1'b0;
        d_valid = 1'b1;
        D_out   = 20'sd800;
        repeat (8) tick;
        chk("refill_eout", E_out, 800);
        chk("refill_filled", filled, 1);

        clear = 1'b1;
        D_out = 20'sd40;
        tick;
        chk("clracc_eout", E_out, 5);
        chk("clracc_filled", filled, 0);
        chk("clracc_count", dut.count, 1);
        clear = 1'b0;
        tick;
        chk("clracc_next", E_out, 10);

        clear = 1'b1;
        D_out = -20'sd1;
        tick;
        chk("avg_floor", E_out, -1);

        mode  = 2'd1;
        D_out = 20'sd524287;
        tick;
        chk("sat_pos1", E_out, 524287);
        clear = 1'b0;
        tick;
        chk("sat_pos2", E_out, 524287);
        clear = 1'b1;
        D_out = -20'sd524288;
        tick;
        chk("sat_neg1", E_out, -524288);
        clear = 1'b0;
        tick;
        chk("sat_neg2", E_out, -524288);

        mode  = 2'd3;
        D_out = -20'sd7;
        tick;
        chk("mode3_pass", E_out, -7);

        clear = 1'b1;
        mode  = 2'd0;
        D_out = 20'sd1000;
        tick;
        chk("hold_setup", E_out, 1000);
        clear   = 1'b0;
        e_ready = 1'b0;
        D_out   = 20'sd77;
        mode    = 2'd2;
        #1;
        chk("hold_dready0", d_ready, 0);
        repeat (3) begin
            tick;
            chk("hold_eout", E_out, 1000);
            chk("hold_evalid", e_valid, 1);
            chk("hold_dready", d_ready, 0);
        end
        mode    = 2'd0;
        e_ready = 1'b1;
        #1;
        chk("release_dready", d_ready, 1);
        tick;
        chk("release_eout", E_out, 77);
        chk("release_evalid", e_valid, 1);
        mode  = 2'd1;
        D_out = 20'sd0;
        tick;
        chk("hold_nodrop_sum", E_out, 1077);

        d_valid = 1'b0;
        tick;
        chk("drain_evalid", e_valid, 0);
        chk("drain_eout", E_out, 1077);

        d_valid = 1'b1;
        D_out   = 20'sd9;
        tick;
        e_ready = 1'b0;
        clear   = 1'b1;
        reset   = 1'b1;
        tick;
        chk("rstov_eout", E_out, 0);
        chk("rstov_evalid", e_valid, 0);
        chk("rstov_filled", filled, 0);
        reset   = 1'b0;
        clear   = 1'b0;
        e_ready = 1'b1;
        mode    = 2'd1;
        D_out   = 20'sd5;
        tick;
        chk("rstov_sum", E_out, 5);
        d_valid = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
